// File: rtl/outlier_scatter.sv
// -----------------------------------------------------------------------------
// outlier_scatter
//
// Collects sparse outlier products (up to NUM_LR lanes per beat, each with a
// dense index and an FP16 value) into a dense DIMM-entry frame.  A frame is
// built over one or more accepted beats.  The beat carrying in_last closes it,
// and the completed frame is then held on the outputs until the downstream
// consumes it.
//
// Ports
//   clk            : clock, all logic on the rising edge
//   rst_n          : synchronous reset, ACTIVE-HIGH despite the name
//   in_valid       : input beat offered
//   in_ready       : block accepts a beat (COLLECT state)
//   in_lane_valid  : per-lane valid mask for the beat
//   in_index       : dense position of each lane's product
//   in_value       : FP16 product of each lane (opaque 16-bit payload)
//   in_last        : beat closes the current frame
//   out_valid      : completed frame presented (HOLD state)
//   out_ready      : downstream consumes the frame
//   out_data       : dense frame; unwritten positions read 16'h0000
//   out_mask       : 1 = position written during the frame
//   out_count      : popcount(out_mask)
//   out_collision  : some position was written more than once in the frame
//
// While collecting, the in-progress frame is visible on the out_* ports and is
// qualified only by out_valid=0.
// -----------------------------------------------------------------------------
module outlier_scatter #(
  parameter int DIMM       = 64,
  parameter int NUM_LR     = 4,
  parameter int IndexWidth = $clog2(DIMM)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_LR-1:0]                   in_lane_valid,
  input  logic [NUM_LR-1:0][IndexWidth-1:0]   in_index,
  input  logic [NUM_LR-1:0][15:0]             in_value,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DIMM-1:0][15:0]               out_data,
  output logic [DIMM-1:0]                     out_mask,
  output logic [$clog2(DIMM+1)-1:0]           out_count,
  output logic                                out_collision
);

  localparam int CountW = $clog2(DIMM+1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [DIMM-1:0][15:0]  buf_q,   buf_d;
  logic [DIMM-1:0]        mask_q,  mask_d;
  logic [CountW-1:0]      count_q, count_d;
  logic                   coll_q,  coll_d;

  // Next-state and frame update
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    mask_d  = mask_q;
    count_d = count_q;
    coll_d  = coll_q;

    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          // Lanes are applied in ascending order against the running mask_d.
          // A position already set -- by an earlier beat or a lower lane of
          // this beat -- flags a collision and is overwritten, so the
          // highest-numbered lane wins and each position is counted once.
          for (int i = 0; i < NUM_LR; i++) begin
            if (in_lane_valid[i]) begin
              if (mask_d[in_index[i]]) begin
                coll_d = 1'b1;
              end else begin
                count_d = count_d + CountW'(1);
              end
              mask_d[in_index[i]] = 1'b1;
              buf_d[in_index[i]]  = in_value[i];
            end
          end
          if (in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Frame consumed: clear everything so the next frame starts empty.
        if (out_ready) begin
          buf_d   = '0;
          mask_d  = '0;
          count_d = '0;
          coll_d  = 1'b0;
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // Registers (reset has priority over any beat or handshake)
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= COLLECT;
      buf_q   <= '0;
      mask_q  <= '0;
      count_q <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      coll_q  <= coll_d;
    end
  end

  // Handshakes decode from registered state only
  assign in_ready      = (state_q == COLLECT);
  assign out_valid     = (state_q == HOLD);
  assign out_data      = buf_q;
  assign out_mask      = mask_q;
  assign out_count     = count_q;
  assign out_collision = coll_q;

endmodule

// File: tb/tb_outlier_scatter.sv
module tb_outlier_scatter;

  localparam int DIMM   = 64;
  localparam int NUM_LR = 4;
  localparam int IW     = 6;
  localparam int CW     = 7;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_LR-1:0]             in_lane_valid;
  logic [NUM_LR-1:0][IW-1:0]     in_index;
  logic [NUM_LR-1:0][15:0]       in_value;
  logic                          in_last;
  logic                          out_valid;
  logic                          out_ready;
  logic [DIMM-1:0][15:0]         out_data;
  logic [DIMM-1:0]               out_mask;
  logic [CW-1:0]                 out_count;
  logic                          out_collision;

  int pass_cnt = 0;
  int total    = 0;

  outlier_scatter #(.DIMM(DIMM), .NUM_LR(NUM_LR), .IndexWidth(IW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_lane_valid (in_lane_valid),
    .in_index      (in_index),
    .in_value      (in_value),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_mask      (out_mask),
    .out_count     (out_count),
    .out_collision (out_collision)
  );

  always #5 clk = ~clk;

  // Single-beat frame vectors. Packed lane fields are written lane3..lane0.
  typedef struct {
    string                     name;
    logic [3:0]                lv;
    logic [3:0][IW-1:0]        idx;
    logic [3:0][15:0]          val;
    int                        npos;
    logic [3:0][IW-1:0]        epos;
    logic [3:0][15:0]          eval;
    logic                      ecoll;
  } vec_t;

  vec_t vt[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_data(input string name, input logic [DIMM-1:0][15:0] exp);
    int bad;
    bad = -1;
    for (int p = DIMM - 1; p >= 0; p--) if (out_data[p] !== exp[p]) bad = p;
    total++;
    if (bad < 0) pass_cnt++;
    else $display("FAIL %s: out_data[%0d] got %h expected %h", name, bad, out_data[bad], exp[bad]);
  endtask

  task automatic drive(input logic [3:0] lv, input logic [3:0][IW-1:0] idx,
                       input logic [3:0][15:0] val, input logic last);
    in_valid      = 1'b1;
    in_lane_valid = lv;
    in_index      = idx;
    in_value      = val;
    in_last       = last;
  endtask

  task automatic idle();
    in_valid      = 1'b0;
    in_lane_valid = '0;
    in_index      = '0;
    in_value      = '0;
    in_last       = 1'b0;
  endtask

  logic [DIMM-1:0][15:0] exp_data;
  logic [DIMM-1:0]       exp_mask;

  initial begin
    vt[0] = '{"req033", 4'b1111, {6'd0, 6'd63, 6'd9, 6'd5},
              {16'h7BFF, 16'hC200, 16'h4000, 16'h3C00},
              4, {6'd0, 6'd63, 6'd9, 6'd5}, {16'h7BFF, 16'hC200, 16'h4000, 16'h3C00}, 1'b0};
    vt[1] = '{"req034", 4'b1010, {6'd12, 6'd3, 6'd12, 6'd3},
              {16'h3333, 16'hFFFF, 16'h1111, 16'hEEEE},
              1, {6'd0, 6'd0, 6'd0, 6'd12}, {16'h0, 16'h0, 16'h0, 16'h3333}, 1'b1};
    vt[2] = '{"nolanes", 4'b0000, {6'd1, 6'd2, 6'd3, 6'd3},
              {16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678},
              0, '0, '0, 1'b0};
    vt[3] = '{"triple", 4'b0111, {6'd40, 6'd40, 6'd40, 6'd40},
              {16'h0009, 16'h0003, 16'h0002, 16'h0001},
              1, {6'd0, 6'd0, 6'd0, 6'd40}, {16'h0, 16'h0, 16'h0, 16'h0003}, 1'b1};
    vt[4] = '{"sparse", 4'b0101, {6'd1, 6'd3, 6'd2, 6'd1},
              {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA},
              2, {6'd0, 6'd0, 6'd3, 6'd1}, {16'h0, 16'h0, 16'hCCCC, 16'hAAAA}, 1'b0};

    // Reset
    idle();
    out_ready = 1'b0;
    rst_n     = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mask", out_mask, 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_coll", 64'(out_collision), 64'd0);
    chk_data("rst_data", '0);

    // Table-driven single-beat frames, released on the first HOLD cycle
    for (int v = 0; v < 5; v++) begin
      exp_data = '0;
      exp_mask = '0;
      for (int k = 0; k < vt[v].npos; k++) begin
        exp_data[vt[v].epos[k]] = vt[v].eval[k];
        exp_mask[vt[v].epos[k]] = 1'b1;
      end
      drive(vt[v].lv, vt[v].idx, vt[v].val, 1'b1);
      step();
      idle();
      chk({vt[v].name, "_out_valid"}, 64'(out_valid), 64'd1);
      chk({vt[v].name, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({vt[v].name, "_mask"}, out_mask, exp_mask);
      chk({vt[v].name, "_count"}, 64'(out_count), 64'(vt[v].npos));
      chk({vt[v].name, "_coll"}, 64'(out_collision), 64'(vt[v].ecoll));
      chk_data({vt[v].name, "_data"}, exp_data);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({vt[v].name, "_rel_valid"}, 64'(out_valid), 64'd0);
      chk({vt[v].name, "_rel_ready"}, 64'(in_ready), 64'd1);
      chk({vt[v].name, "_rel_mask"}, out_mask, 64'd0);
      chk({vt[v].name, "_rel_count"}, 64'(out_count), 64'd0);
    end

    // Cross-beat overwrite: A writes 7, B (last) writes 7 and 8
    drive(4'b0001, {6'd0, 6'd0, 6'd0, 6'd7}, {16'h0, 16'h0, 16'h0, 16'hAAAA}, 1'b0);
    step();
    idle();
    chk("ovw_mid_valid", 64'(out_valid), 64'd0);
    chk("ovw_mid_ready", 64'(in_ready), 64'd1);
    chk("ovw_mid_count", 64'(out_count), 64'd1);
    chk("ovw_mid_d7", 64'(out_data[7]), 64'hAAAA);
    drive(4'b0011, {6'd0, 6'd0, 6'd8, 6'd7}, {16'h0, 16'h0, 16'hCCCC, 16'hBBBB}, 1'b1);
    step();
    exp_data    = '0;
    exp_data[7] = 16'hBBBB;
    exp_data[8] = 16'hCCCC;
    exp_mask    = '0;
    exp_mask[7] = 1'b1;
    exp_mask[8] = 1'b1;
    chk("ovw_valid", 64'(out_valid), 64'd1);
    chk("ovw_count", 64'(out_count), 64'd2);
    chk("ovw_coll", 64'(out_collision), 64'd1);
    chk_data("ovw_data", exp_data);

    // Held frame under back-pressure while new beats are offered
    drive(4'b1111, {6'd20, 6'd21, 6'd22, 6'd7}, {16'h5555, 16'h6666, 16'h7777, 16'h8888}, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_mask", out_mask, exp_mask);
      chk("hold_count", 64'(out_count), 64'd2);
      chk("hold_coll", 64'(out_collision), 64'd1);
      chk_data("hold_data", exp_data);
    end
    idle();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hrel_valid", 64'(out_valid), 64'd0);
    chk("hrel_ready", 64'(in_ready), 64'd1);
    chk("hrel_mask", out_mask, 64'd0);
    chk("hrel_count", 64'(out_count), 64'd0);

    // Back-to-back frames: release on first HOLD cycle, next beat offered throughout
    drive(4'b0001, {6'd0, 6'd0, 6'd0, 6'd30}, {16'h0, 16'h0, 16'h0, 16'h1234}, 1'b1);
    step();
    chk("b2b_hold", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    drive(4'b0001, {6'd0, 6'd0, 6'd0, 6'd31}, {16'h0, 16'h0, 16'h0, 16'h5678}, 1'b0);
    step();
    out_ready = 1'b0;
    chk("b2b_ready", 64'(in_ready), 64'd1);
    chk("b2b_empty", out_mask, 64'd0);
    step();
    idle();
    exp_data     = '0;
    exp_data[31] = 16'h5678;
    chk("b2b_mask", out_mask, 64'h0000_0000_8000_0000);
    chk("b2b_count", 64'(out_count), 64'd1);
    chk_data("b2b_data", exp_data);

    // Reset while HOLD and out_ready both active
    drive(4'b0001, {6'd0, 6'd0, 6'd0, 6'd50}, {16'h0, 16'h0, 16'h0, 16'h9999}, 1'b1);
    step();
    chk("rsth_pre", 64'(out_valid), 64'd1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle();
    chk("rsth_valid", 64'(out_valid), 64'd0);
    chk("rsth_ready", 64'(in_ready), 64'd1);
    chk("rsth_mask", out_mask, 64'd0);
    chk("rsth_count", 64'(out_count), 64'd0);
    chk("rsth_coll", 64'(out_collision), 64'd0);
    chk_data("rsth_data", '0);

    // Reset in the same cycle as an accepted beat
    drive(4'b0011, {6'd0, 6'd0, 6'd2, 6'd2}, {16'h0, 16'h0, 16'h4444, 16'h3333}, 1'b1);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    idle();
    chk("rstb_valid", 64'(out_valid), 64'd0);
    chk("rstb_mask", out_mask, 64'd0);
    chk("rstb_count", 64'(out_count), 64'd0);
    chk("rstb_coll", 64'(out_collision), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
